lsu_mem_port: RTL

Load/store unit for the RV32I core. It sits between the datapath and the data-memory bus.
- Takes the ALU result as the address, rs2 as store data, and funct3 as size/sign.
- Runs a request/grant/response handshake on the memory side.
- Returns the aligned, sign- or zero-extended load value on `DataOut`, which is the memory-side input of the writeback select.
- Stalls the core for the duration of each access.

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/lsu_load_extract.sv | 30 +++
 rtl/lsu_mem_port.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, FSM states and helpers for the load/store unit
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic logic [3:0] lane_wstrb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    lane_wstrb = 4'b0001 << off;
      SZ_H:    lane_wstrb = 4'b0011 << off;
      default: lane_wstrb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_B:    lane_wdata = {4{data[7:0]}};
      SZ_H:    lane_wdata = {2{data[15:0]}};
      default: lane_wdata = data;
    endcase
  endfunction

  // Only meaningful while rd|wr is asserted.
  function automatic logic req_valid(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [1:0] off);
    logic legal;
    logic aligned;
    if (rd) legal = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    else    legal = (f3 == SB) || (f3 == SH) || (f3 == SW);
    case (f3[1:0])
      SZ_H:    aligned = ~off[0];
      SZ_W:    aligned = (off == 2'b00);
      default: aligned = 1'b1;
    endcase
    return !(rd && wr) && legal && aligned;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// rtl/lsu_load_extract.sv - selects and sign/zero-extends a byte, halfword or word from a read word
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B:    value = {{24{sign & byte_sel[7]}}, byte_sel};
      SZ_H:    value = {{16{sign & half_sel[15]}}, half_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - RV32I load/store unit: request/grant/response bus port with watchdog
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] rs2,
  output logic [31:0] DataOut,
  output logic        stall,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] wd_cnt;
  logic [1:0]    size_q;
  logic [1:0]    off_q;
  logic          sign_q;
  logic          access;
  logic          valid;
  logic          wd_expired;
  logic [31:0]   load_val;

  assign access     = MemRead | MemWrite;
  assign valid      = req_valid(MemRead, MemWrite, funct3, addr[1:0]);
  assign wd_expired = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

  // A grant or response on the last allowed cycle still completes the access.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    mem_req    = 1'b0;
    lsu_done   = 1'b0;
    lsu_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = rst_n & access & valid;
        if (access) state_next = valid ? ST_REQ : ST_ERR;
      end
      ST_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt)         state_next = mem_we ? ST_DONE : ST_RESP;
        else if (wd_expired) state_next = ST_ERR;
      end
      ST_RESP: begin
        stall = 1'b1;
        if (mem_rvalid)      state_next = ST_DONE;
        else if (wd_expired) state_next = ST_ERR;
      end
      ST_DONE: begin
        lsu_done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        lsu_err    = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      size_q    <= '0;
      off_q     <= '0;
      sign_q    <= 1'b0;
    end else if (state == ST_IDLE && access && valid) begin
      mem_we    <= MemWrite;
      mem_addr  <= {addr[31:2], 2'b00};
      mem_wstrb <= MemWrite ? lane_wstrb(funct3[1:0], addr[1:0]) : 4'b0000;
      mem_wdata <= MemWrite ? lane_wdata(funct3[1:0], rs2) : 32'h0;
      size_q    <= funct3[1:0];
      off_q     <= addr[1:0];
      sign_q    <= ~funct3[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    wd_cnt <= '0;
    else if (state == ST_IDLE)                     wd_cnt <= '0;
    else if (state == ST_REQ || state == ST_RESP)  wd_cnt <= wd_cnt + 1'b1;
  end

  lsu_load_extract u_extract (
    .rdata  (mem_rdata),
    .offset (off_q),
    .size   (size_q),
    .sign   (sign_q),
    .value  (load_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 DataOut <= '0;
    else if (state == ST_RESP && mem_rvalid)    DataOut <= load_val;
  end

endmodule
